// File: rtl/sa_out_reader.sv
// sa_out_reader
//   Takes the systolic array's parallel result matrix, which arrives as a
//   single-cycle pulse, and holds it in a two-entry ping-pong buffer. It then
//   streams the buffered matrices out one row per valid/ready handshake. The
//   array cannot be stalled, so a matrix that arrives while both entries are
//   full is discarded, and a saturating counter records how many were lost.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   i_matrix_vld   one-cycle pulse: i_matrix is valid this cycle
//   i_matrix       result matrix, indexed [row][col]
//   o_row_vld      o_row holds a valid row
//   i_row_rdy      downstream accepts the row this cycle
//   o_row          current row, indexed [col]
//   o_row_idx      index of the current row
//   o_row_last     current row is the last row of its matrix
//   o_level        number of occupied buffer entries (0..2)
//   o_drop         one-cycle pulse, one cycle after a matrix was discarded
//   o_drop_cnt     saturating count of discarded matrices
module sa_out_reader #(
  parameter int SIZE       = 4,
  parameter int O_WIDTH    = 60,
  parameter int DCNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_matrix_vld,
  input  logic [O_WIDTH-1:0]        i_matrix [SIZE][SIZE],
  output logic                      o_row_vld,
  input  logic                      i_row_rdy,
  output logic [O_WIDTH-1:0]        o_row [SIZE],
  output logic [$clog2(SIZE)-1:0]   o_row_idx,
  output logic                      o_row_last,
  output logic [1:0]                o_level,
  output logic                      o_drop,
  output logic [DCNT_WIDTH-1:0]     o_drop_cnt
);

  localparam int IDX_W = $clog2(SIZE);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(SIZE - 1);

  // Data storage carries no reset; level_q alone decides what is valid.
  logic [O_WIDTH-1:0] mem_q [2][SIZE][SIZE];
  logic [O_WIDTH-1:0] mem_d [2][SIZE][SIZE];

  logic                  wr_ptr_q,   wr_ptr_d;
  logic                  rd_ptr_q,   rd_ptr_d;
  logic [1:0]            level_q,    level_d;
  logic [IDX_W-1:0]      row_cnt_q,  row_cnt_d;
  logic [DCNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                  drop_q,     drop_d;

  logic hs;
  logic mdone;
  logic accept;
  logic drop_now;

  assign o_row_vld  = (level_q != 2'd0);
  assign o_row_idx  = row_cnt_q;
  assign o_row_last = o_row_vld & (row_cnt_q == LAST_ROW);
  assign o_level    = level_q;
  assign o_drop     = drop_q;
  assign o_drop_cnt = drop_cnt_q;

  always_comb begin
    o_row = mem_q[rd_ptr_q][row_cnt_q];
  end

  assign hs    = o_row_vld & i_row_rdy;
  assign mdone = hs & (row_cnt_q == LAST_ROW);
  // The entry freed by a finishing matrix is reusable in the same cycle,
  // so a full buffer still takes a new matrix while it finishes one.
  assign accept   = i_matrix_vld & ((level_q != 2'd2) | mdone);
  assign drop_now = i_matrix_vld & ~accept;

  always_comb begin
    mem_d = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q] = i_matrix;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q ^ accept;
    rd_ptr_d   = rd_ptr_q ^ mdone;
    level_d    = level_q + {1'b0, accept} - {1'b0, mdone};
    row_cnt_d  = row_cnt_q;
    drop_d     = drop_now;
    drop_cnt_d = drop_cnt_q;
    if (mdone) begin
      row_cnt_d = '0;
    end else if (hs) begin
      row_cnt_d = row_cnt_q + IDX_W'(1);
    end
    if (drop_now && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      level_q    <= 2'd0;
      row_cnt_q  <= '0;
      drop_cnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      row_cnt_q  <= row_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      drop_q     <= drop_d;
    end
  end

endmodule
